// File: rtl/asym_fifo_pkg.sv
// Shared helpers for the asymmetric FIFO: ceiling log2 and integer max/min,
// used for address, pointer and level widths.
package asym_fifo_pkg;

    // Ceiling log2. The result is 0 for v <= 1.
    function automatic int log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/asym_ram_sdp_1clk.sv
// Simple dual-port RAM on one clock. It has a wide write port and a narrow,
// registered read port. The read register doubles as the FIFO output
// register, so it is the only part of the RAM that resets.
module asym_ram_sdp_1clk #(
    parameter int WIDTHA = 16,
    parameter int WIDTHB = 4,
    parameter int SIZEA  = 256,
    parameter int AWA    = 8,
    parameter int AWB    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWA-1:0]    waddr,
    input  logic [WIDTHA-1:0] wdata,
    input  logic              re,
    input  logic [AWB-1:0]    raddr,
    output logic [WIDTHB-1:0] dout
);
    localparam int RATIO = WIDTHA / WIDTHB;
    localparam int SL    = AWB - AWA;

    logic [WIDTHA-1:0]             mem [SIZEA];
    logic [RATIO-1:0][WIDTHB-1:0]  rdSlices;

    // Index 0 of the slice view is the LSB slice of the wide word.
    assign rdSlices = mem[raddr[AWB-1:SL]];

    // Wide write port. The contents are left unreset so that the array maps
    // onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Narrow registered read. It loads only when the FIFO pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     dout <= '0;
        else if (re) dout <= rdSlices[raddr[SL-1:0]];
    end

endmodule

// File: rtl/asym_fifo_write_wider.sv
// Single-clock asymmetric FIFO. Each write is one wide word of WIDTHA bits.
// Each read is one narrow word of WIDTHB bits, taken LSB slice first.
// Optional fill level and almost-full outputs: define ASYM_FIFO_LEVEL_EN.
module asym_fifo_write_wider
    import asym_fifo_pkg::*;
#(
    parameter int WIDTHA   = 16,
    parameter int WIDTHB   = 4,
    parameter int SIZEA    = 256,
    parameter int AFULL_TH = SIZEA * (WIDTHA / WIDTHB) - WIDTHA / WIDTHB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WIDTHA-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WIDTHB-1:0] rd_data
`ifdef ASYM_FIFO_LEVEL_EN
    ,
    output logic [log2(SIZEA * (WIDTHA / WIDTHB)) + 1:0] level,
    output logic                                          almost_full
`endif
);
    localparam int RATIO = WIDTHA / WIDTHB;
    localparam int SIZEB = SIZEA * RATIO;
    localparam int SL    = log2(RATIO);
    localparam int AWA   = log2(SIZEA);
    localparam int AWB   = log2(SIZEB);

    localparam logic [AWB:0] SIZEB_P = SIZEB[AWB:0];
    localparam logic [AWB:0] RATIO_P = RATIO[AWB:0];

    // Both pointers carry one extra wrap bit. The write pointer counts wide
    // words and the read pointer counts narrow words. Scaling the write
    // pointer by RATIO, i.e. appending SL zeros, puts both on one scale.
    logic [AWA:0] wptr, wptrNext;
    logic [AWB:0] rptr, rptrNext;
    logic [AWB:0] ramCnt;
    logic         rdValid, rdValidNext;
    logic         wrEn, load;

    assign ramCnt   = {wptr, {SL{1'b0}}} - rptr;
    assign wr_ready = !rst && ((SIZEB_P - ramCnt) >= RATIO_P);
    assign wrEn     = wr_valid && wr_ready;
    assign load     = (ramCnt != '0) && (!rdValid || rd_ready);
    assign rd_valid = rdValid;

    // Next-state values for the pointers and the output-valid flag.
    always_comb begin
        wptrNext    = wrEn ? wptr + 1'b1 : wptr;
        rptrNext    = load ? rptr + 1'b1 : rptr;
        rdValidNext = rdValid;
        if (load)                      rdValidNext = 1'b1;
        else if (rdValid && rd_ready)  rdValidNext = 1'b0;
    end

    // Pointer and output-valid state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            rdValid <= 1'b0;
        end else begin
            wptr    <= wptrNext;
            rptr    <= rptrNext;
            rdValid <= rdValidNext;
        end
    end

    // The write address never aliases the word being read.
    // wr_ready guarantees at least one free wide word at wptr.
    asym_ram_sdp_1clk #(
        .WIDTHA(WIDTHA),
        .WIDTHB(WIDTHB),
        .SIZEA (SIZEA),
        .AWA   (AWA),
        .AWB   (AWB)
    ) uRam (
        .clk  (clk),
        .rst  (rst),
        .we   (wrEn),
        .waddr(wptr[AWA-1:0]),
        .wdata(wr_data),
        .re   (load),
        .raddr(rptr[AWB-1:0]),
        .dout (rd_data)
    );

`ifdef ASYM_FIFO_LEVEL_EN
    localparam int LVLW = AWB + 2;
    localparam logic [LVLW-1:0] AFTH_P = LVLW'(AFULL_TH);

    logic [AWB:0]      ramCntNext;
    logic [LVLW-1:0]   levelNext;

    assign ramCntNext = {wptrNext, {SL{1'b0}}} - rptrNext;
    assign levelNext  = {1'b0, ramCntNext} + {{(AWB + 1){1'b0}}, rdValidNext};

    // Level and almost_full are registered from next-state values.
    // level therefore always equals ram_cnt + rd_valid for the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= levelNext;
            almost_full <= (levelNext >= AFTH_P);
        end
    end
`endif

endmodule

// File: tb/tb_asym_fifo_write_wider.sv
// Directed self-checking bench for asym_fifo_write_wider.
// Configuration: WIDTHA=16, WIDTHB=4, SIZEA=4, AFULL_TH=12.
// The level and almost_full checks are compiled in only when
// ASYM_FIFO_LEVEL_EN is defined.
module tb_asym_fifo_write_wider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [3:0]  rd_data;
`ifdef ASYM_FIFO_LEVEL_EN
    logic [5:0]  level;
    logic        almost_full;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    asym_fifo_write_wider #(
        .WIDTHA(16), .WIDTHB(4), .SIZEA(4), .AFULL_TH(12)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data)
`ifdef ASYM_FIFO_LEVEL_EN
        , .level(level), .almost_full(almost_full)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkLvl(input string tag, input logic [31:0] lv, input logic [31:0] af);
`ifdef ASYM_FIFO_LEVEL_EN
        chk({tag, "_level"}, 32'(level), lv);
        chk({tag, "_afull"}, 32'(almost_full), af);
`else
        if (lv === 32'hFFFF_FFFF || af === 32'hFFFF_FFFF) chk(tag, 0, 0);
`endif
    endtask

    // Advance one clock edge, then settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, k, cyc;
        logic [15:0] w;

        // Reset state.
        #2;
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data",  32'(rd_data), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chkLvl("rst", 0, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_wr_ready", 32'(wr_ready), 1);

        // Single wide write. Slices come out LSB first, starting one edge after the write.
        rd_ready = 1'b1;
        wr_valid = 1'b1; wr_data = 16'hABCD;
        tick();
        wr_valid = 1'b0;
        chk("lat_not_yet", 32'(rd_valid), 0);
        chkLvl("lat_n", 4, 0);
        tick(); chk("abcd_v0", 32'(rd_valid), 1); chk("abcd_d0", 32'(rd_data), 4'hD);
        chkLvl("abcd_n1", 4, 0);
        tick(); chk("abcd_d1", 32'(rd_data), 4'hC);
        tick(); chk("abcd_d2", 32'(rd_data), 4'hB);
        tick(); chk("abcd_d3", 32'(rd_data), 4'hA); chkLvl("abcd_last", 1, 0);
        tick(); chk("abcd_empty", 32'(rd_valid), 0); chkLvl("abcd_empty", 0, 0);

        // Fill to full with the consumer stalled.
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data = 16'h1111; tick(); chkLvl("fill1", 4, 0);
        wr_data = 16'h2222; tick(); chkLvl("fill2", 8, 0);
        wr_data = 16'h3333; tick(); chkLvl("fill3", 12, 1);
        chk("fill3_wr_ready", 32'(wr_ready), 1);
        wr_data = 16'h4444; tick();
        chk("full_wr_ready", 32'(wr_ready), 0); chkLvl("full", 16, 1);
        wr_data = 16'h5555; tick();
        wr_valid = 1'b0;
        chkLvl("ignored_write", 16, 1);
        chk("full_hold_v", 32'(rd_valid), 1);
        chk("full_hold_d", 32'(rd_data), 1);

        // Pop from full. wr_ready must be 0 after one pop and 1 after four.
        rd_ready = 1'b1;
        tick();
        chk("pop1_wr_ready", 32'(wr_ready), 0);
        chk("pop1_d", 32'(rd_data), 1);
        tick(); tick(); tick();
        chk("pop4_wr_ready", 32'(wr_ready), 1);
        chkLvl("pop4", 12, 1);
        // Drain. Expected sequence: 2,2,2,2,3,3,3,3,4,4,4,4. The 5555 write must never appear.
        for (int i = 0; i < 12; i++) begin
            chk("drain_v", 32'(rd_valid), 1);
            chk("drain_d", 32'(rd_data), 32'(i / 4 + 2));
            tick();
        end
        chk("drain_empty", 32'(rd_valid), 0);
        chkLvl("drain_empty", 0, 0);

        // Stream 40 wide words through with rd_ready held high.
        // The pointers wrap several times.
        n = 0; k = 0; cyc = 0;
        while (n < 160 && cyc < 400) begin
            if (rd_valid) begin
                w = 16'(n / 4);
                chk("stream_d", 32'(rd_data), 32'((w >> (4 * (n % 4))) & 16'hF));
                n++;
            end
            wr_valid = (k < 40);
            wr_data  = 16'(k);
            #0;
            if (wr_valid && wr_ready) k++;
            tick();
            wr_valid = 1'b0;
            cyc++;
        end
        chk("stream_count", 32'(n), 160);
        chk("stream_writes", 32'(k), 40);
        tick();
        chk("stream_empty", 32'(rd_valid), 0);

        // Reset mid-stream discards everything.
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data = 16'h1234; tick();
        wr_data = 16'h5678; tick();
        wr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_v", 32'(rd_valid), 0);
        chk("mid_rst_wr_ready", 32'(wr_ready), 0);
        chkLvl("mid_rst", 0, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("after_rst_v", 32'(rd_valid), 0);
        chk("after_rst_wr_ready", 32'(wr_ready), 1);
        chkLvl("after_rst", 0, 0);
        rd_ready = 1'b1;
        wr_valid = 1'b1; wr_data = 16'h00F0;
        tick();
        wr_valid = 1'b0;
        tick(); chk("f0_d0", 32'(rd_data), 0); chk("f0_v0", 32'(rd_valid), 1);
        tick(); chk("f0_d1", 32'(rd_data), 4'hF);
        tick(); chk("f0_d2", 32'(rd_data), 0);
        tick(); chk("f0_d3", 32'(rd_data), 0); chk("f0_v3", 32'(rd_valid), 1);
        tick(); chk("f0_empty", 32'(rd_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
